// File: rtl/n101_spi_padport.sv
`default_nettype none
// ============================================================================
// Module  : n101_spi_padport
// Purpose : Parametrised SPI-to-GPIO pad port. Retimes every pad control
//           output, runs a per-lane OUT/TURN/IN turnaround FSM so a DQ pad
//           never has OE and IE high together, and synchronises plus delays
//           sampled DQ data before returning it to the controller.
// Ports   : clk, rst_n                 core clock, async active-low reset
//           cfg_en, cfg_cs_pol,        enable, per-CS polarity (1=active-high)
//           cfg_rx_dly, cfg_ds         extra RX delay, pad drive strength
//           spi_sck/dq_o/dq_oe/cs      controller side outputs
//           spi_dq_i, lane_turn        sampled data, per-lane TURN flag
//           pins_{sck,dq,cs}_*         pad control / pad input buses
// Options : N101_SPI_PADPORT_LOOPBACK_EN adds cfg_lpbk; when set, the RX
//           delay line is fed from registered spi_dq_o and all DQ OE are 0.
// Rev     : 1.0  initial release
// ============================================================================
module n101_spi_padport #(
    parameter int DQ_W        = 4,
    parameter int CS_W        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_DLY     = 3,
    parameter int TURN_CYC    = 1,
    parameter int DLY_W       = $clog2(MAX_DLY + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_en,
    input  logic [CS_W-1:0]   cfg_cs_pol,
    input  logic [DLY_W-1:0]  cfg_rx_dly,
    input  logic              cfg_ds,
`ifdef N101_SPI_PADPORT_LOOPBACK_EN
    input  logic              cfg_lpbk,
`endif
    input  logic              spi_sck,
    input  logic [DQ_W-1:0]   spi_dq_o,
    input  logic [DQ_W-1:0]   spi_dq_oe,
    output logic [DQ_W-1:0]   spi_dq_i,
    input  logic [CS_W-1:0]   spi_cs,
    output logic [DQ_W-1:0]   lane_turn,
    input  logic              pins_sck_i_ival,
    output logic              pins_sck_o_oval,
    output logic              pins_sck_o_oe,
    output logic              pins_sck_o_ie,
    output logic              pins_sck_o_pue,
    output logic              pins_sck_o_ds,
    input  logic [DQ_W-1:0]   pins_dq_i_ival,
    output logic [DQ_W-1:0]   pins_dq_o_oval,
    output logic [DQ_W-1:0]   pins_dq_o_oe,
    output logic [DQ_W-1:0]   pins_dq_o_ie,
    output logic [DQ_W-1:0]   pins_dq_o_pue,
    output logic [DQ_W-1:0]   pins_dq_o_ds,
    input  logic [CS_W-1:0]   pins_cs_i_ival,
    output logic [CS_W-1:0]   pins_cs_o_oval,
    output logic [CS_W-1:0]   pins_cs_o_oe,
    output logic [CS_W-1:0]   pins_cs_o_ie,
    output logic [CS_W-1:0]   pins_cs_o_pue,
    output logic [CS_W-1:0]   pins_cs_o_ds
);

    // One spare bit keeps the "more than one cycle left" compare meaningful
    // even when TURN_CYC fits in a single bit.
    localparam int c_CNT_W = $clog2(TURN_CYC + 1) + 1;
    localparam logic [c_CNT_W-1:0] c_TURN_LD = c_CNT_W'(TURN_CYC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OUT  = 2'd1,
        ST_TURN = 2'd2,
        ST_IN   = 2'd3
    } lane_state_t;

    logic w_lpbk;
`ifdef N101_SPI_PADPORT_LOOPBACK_EN
    assign w_lpbk = cfg_lpbk;
`else
    assign w_lpbk = 1'b0;
`endif

    // Pad inputs that exist only for bus symmetry.
    logic w_unused;
    assign w_unused = ^{pins_sck_i_ival, pins_cs_i_ival};

    // ------------------------------------------------------------------
    // Output-side registers
    // ------------------------------------------------------------------
    logic            r_sck_oval;
    logic            r_sck_oe;
    logic            r_ds;
    logic [CS_W-1:0] r_cs_sel;
    logic            r_cs_oe;
    logic [DQ_W-1:0] r_dq_oval;
    logic [DQ_W-1:0] r_dq_oe;
    logic [DQ_W-1:0] r_dq_ie;
    logic [DQ_W-1:0] r_turn;
    logic [DQ_W-1:0] r_rx;

    logic [DQ_W-1:0] w_oe_nxt;
    logic [DQ_W-1:0] w_ie_nxt;
    logic [DQ_W-1:0] w_turn_nxt;
    logic [DQ_W-1:0] w_in_now;
    logic [DQ_W-1:0] w_tap;

    // ------------------------------------------------------------------
    // Per-lane turnaround FSM. Pad enables are registered from the next
    // state, so OE and IE switch on the same edge as the state itself.
    // ------------------------------------------------------------------
    for (genvar l = 0; l < DQ_W; l++) begin : g_lane
        lane_state_t        r_state;
        lane_state_t        w_nxt;
        logic [c_CNT_W-1:0] r_cnt;
        logic [c_CNT_W-1:0] w_cnt_nxt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        always_comb begin
            w_nxt     = r_state;
            w_cnt_nxt = r_cnt;
            if (!cfg_en) begin
                w_nxt     = ST_IDLE;
                w_cnt_nxt = '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (spi_dq_oe[l]) begin
                            w_nxt = ST_OUT;
                        end else begin
                            w_nxt     = ST_TURN;
                            w_cnt_nxt = c_TURN_LD;
                        end
                    end
                    ST_OUT: begin
                        if (!spi_dq_oe[l]) begin
                            w_nxt     = ST_TURN;
                            w_cnt_nxt = c_TURN_LD;
                        end
                    end
                    ST_TURN: begin
                        if (spi_dq_oe[l]) begin
                            w_nxt     = ST_OUT;
                            w_cnt_nxt = '0;
                        end else if (r_cnt > c_CNT_W'(1)) begin
                            w_cnt_nxt = r_cnt - c_CNT_W'(1);
                        end else begin
                            // Last turnaround cycle: counter reaches zero.
                            w_nxt     = ST_IN;
                            w_cnt_nxt = '0;
                        end
                    end
                    ST_IN: begin
                        if (spi_dq_oe[l]) begin
                            w_nxt = ST_OUT;
                        end
                    end
                    default: begin
                        w_nxt     = ST_IDLE;
                        w_cnt_nxt = '0;
                    end
                endcase
            end
        end

        // Loopback keeps the FSM running but never drives the pad.
        assign w_oe_nxt[l]   = (w_nxt == ST_OUT) && !w_lpbk;
        assign w_ie_nxt[l]   = (w_nxt == ST_IN);
        assign w_turn_nxt[l] = (w_nxt == ST_TURN);
        assign w_in_now[l]   = (r_state == ST_IN);
    end

    // ------------------------------------------------------------------
    // Input path: synchroniser, then a MAX_DLY-deep shift line tapped by
    // the (saturated) delay select. Tap 0 is the line input itself.
    // ------------------------------------------------------------------
    logic [DQ_W-1:0]  r_sync [SYNC_STAGES];
    logic [DQ_W-1:0]  r_dly  [MAX_DLY];
    logic [DQ_W-1:0]  w_taps [MAX_DLY+1];
    logic [DQ_W-1:0]  w_feed;
    logic [DLY_W-1:0] w_dly_sel;

    assign w_feed    = w_lpbk ? r_dq_oval : r_sync[SYNC_STAGES-1];
    assign w_taps[0] = w_feed;

    for (genvar k = 1; k <= MAX_DLY; k++) begin : g_tap
        assign w_taps[k] = r_dly[k-1];
    end

    // Saturation only exists when the select can encode values past MAX_DLY.
    if ((2 ** DLY_W) - 1 > MAX_DLY) begin : g_sat
        assign w_dly_sel = (cfg_rx_dly > DLY_W'(MAX_DLY)) ? DLY_W'(MAX_DLY)
                                                          : cfg_rx_dly;
    end else begin : g_nosat
        assign w_dly_sel = cfg_rx_dly;
    end

    assign w_tap = w_taps[w_dly_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            for (int d = 0; d < MAX_DLY; d++)     r_dly[d]  <= '0;
        end else begin
            r_sync[0] <= pins_dq_i_ival;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_dly[0] <= w_feed;
            for (int d = 1; d < MAX_DLY; d++)     r_dly[d]  <= r_dly[d-1];
        end
    end

    // ------------------------------------------------------------------
    // Registered pad controls and returned data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_oval <= 1'b0;
            r_sck_oe   <= 1'b0;
            r_ds       <= 1'b0;
            r_cs_sel   <= '0;
            r_cs_oe    <= 1'b0;
            r_dq_oval  <= '0;
            r_dq_oe    <= '0;
            r_dq_ie    <= '0;
            r_turn     <= '0;
            r_rx       <= '0;
        end else begin
            r_sck_oval <= spi_sck;
            r_sck_oe   <= cfg_en;
            r_ds       <= cfg_ds;
            r_cs_sel   <= cfg_en ? spi_cs : '0;
            // CS pads are driven from the first enabled cycle onward.
            r_cs_oe    <= r_cs_oe | cfg_en;
            r_dq_oval  <= spi_dq_o;
            r_dq_oe    <= w_oe_nxt;
            r_dq_ie    <= w_ie_nxt;
            r_turn     <= w_turn_nxt;
            // Gate on the lane's present state; the line keeps shifting.
            r_rx       <= w_tap & w_in_now;
        end
    end

    // Polarity is applied after the flop so the reset/disabled level tracks
    // cfg_cs_pol live and always reads as deasserted.
    assign pins_cs_o_oval  = r_cs_sel ^ ~cfg_cs_pol;
    assign pins_cs_o_oe    = {CS_W{r_cs_oe}};
    assign pins_cs_o_ie    = '0;
    assign pins_cs_o_pue   = '0;
    assign pins_cs_o_ds    = {CS_W{r_ds}};

    assign pins_sck_o_oval = r_sck_oval;
    assign pins_sck_o_oe   = r_sck_oe;
    assign pins_sck_o_ie   = 1'b0;
    assign pins_sck_o_pue  = 1'b0;
    assign pins_sck_o_ds   = r_ds;

    assign pins_dq_o_oval  = r_dq_oval;
    assign pins_dq_o_oe    = r_dq_oe;
    assign pins_dq_o_ie    = r_dq_ie;
    assign pins_dq_o_pue   = '1;
    assign pins_dq_o_ds    = {DQ_W{r_ds}};

    assign spi_dq_i        = r_rx;
    assign lane_turn       = r_turn;

endmodule
`default_nettype wire

// File: tb/tb_n101_spi_padport.sv
`default_nettype none
// ============================================================================
// Module  : tb_n101_spi_padport
// Purpose : Directed self-checking bench for n101_spi_padport. Uses
//           MAX_DLY = 5 so a 3-bit delay select can exercise saturation.
//           Loopback checks are built when N101_SPI_PADPORT_LOOPBACK_EN is set.
// Rev     : 1.0  initial release
// ============================================================================
module tb_n101_spi_padport;

    localparam int DQ_W        = 4;
    localparam int CS_W        = 4;
    localparam int SYNC_STAGES = 2;
    localparam int MAX_DLY     = 5;
    localparam int TURN_CYC    = 1;
    localparam int DLY_W       = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_en;
    logic [CS_W-1:0]  cfg_cs_pol;
    logic [DLY_W-1:0] cfg_rx_dly;
    logic             cfg_ds;
    logic             cfg_lpbk;
    logic             spi_sck;
    logic [DQ_W-1:0]  spi_dq_o;
    logic [DQ_W-1:0]  spi_dq_oe;
    logic [DQ_W-1:0]  spi_dq_i;
    logic [CS_W-1:0]  spi_cs;
    logic [DQ_W-1:0]  lane_turn;
    logic             sck_ival;
    logic             sck_oval, sck_oe, sck_ie, sck_pue, sck_ds;
    logic [DQ_W-1:0]  dq_ival;
    logic [DQ_W-1:0]  dq_oval, dq_oe, dq_ie, dq_pue, dq_ds;
    logic [CS_W-1:0]  cs_ival;
    logic [CS_W-1:0]  cs_oval, cs_oe, cs_ie, cs_pue, cs_ds;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    n101_spi_padport #(
        .DQ_W        (DQ_W),
        .CS_W        (CS_W),
        .SYNC_STAGES (SYNC_STAGES),
        .MAX_DLY     (MAX_DLY),
        .TURN_CYC    (TURN_CYC)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_en          (cfg_en),
        .cfg_cs_pol      (cfg_cs_pol),
        .cfg_rx_dly      (cfg_rx_dly),
        .cfg_ds          (cfg_ds),
`ifdef N101_SPI_PADPORT_LOOPBACK_EN
        .cfg_lpbk        (cfg_lpbk),
`endif
        .spi_sck         (spi_sck),
        .spi_dq_o        (spi_dq_o),
        .spi_dq_oe       (spi_dq_oe),
        .spi_dq_i        (spi_dq_i),
        .spi_cs          (spi_cs),
        .lane_turn       (lane_turn),
        .pins_sck_i_ival (sck_ival),
        .pins_sck_o_oval (sck_oval),
        .pins_sck_o_oe   (sck_oe),
        .pins_sck_o_ie   (sck_ie),
        .pins_sck_o_pue  (sck_pue),
        .pins_sck_o_ds   (sck_ds),
        .pins_dq_i_ival  (dq_ival),
        .pins_dq_o_oval  (dq_oval),
        .pins_dq_o_oe    (dq_oe),
        .pins_dq_o_ie    (dq_ie),
        .pins_dq_o_pue   (dq_pue),
        .pins_dq_o_ds    (dq_ds),
        .pins_cs_i_ival  (cs_ival),
        .pins_cs_o_oval  (cs_oval),
        .pins_cs_o_oe    (cs_oe),
        .pins_cs_o_ie    (cs_ie),
        .pins_cs_o_pue   (cs_pue),
        .pins_cs_o_ds    (cs_ds)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // OE and IE on the same DQ pad must never coincide.
    always @(negedge clk) begin
        if (rst_n) chk("oe_ie_overlap", 32'(dq_oe & dq_ie), 32'd0);
    end

    initial begin
        rst_n      = 1'b1;
        cfg_en     = 1'b0;
        cfg_cs_pol = 4'b0010;
        cfg_rx_dly = 3'd0;
        cfg_ds     = 1'b0;
        cfg_lpbk   = 1'b0;
        spi_sck    = 1'b0;
        spi_dq_o   = 4'h0;
        spi_dq_oe  = 4'h0;
        spi_cs     = 4'hF;
        sck_ival   = 1'b0;
        dq_ival    = 4'h0;
        cs_ival    = 4'h0;
        #1 rst_n = 1'b0;
        #1;

        // Reset state
        chk("rst_cs_oval",  32'(cs_oval),  32'hD);
        chk("rst_cs_oe",    32'(cs_oe),    32'h0);
        chk("rst_dq_oe",    32'(dq_oe),    32'h0);
        chk("rst_dq_ie",    32'(dq_ie),    32'h0);
        chk("rst_dq_pue",   32'(dq_pue),   32'hF);
        chk("rst_spi_dq_i", 32'(spi_dq_i), 32'h0);
        chk("rst_turn",     32'(lane_turn), 32'h0);

        ticks(2);
        rst_n = 1'b1;
        tick();
        chk("dis_cs_oval", 32'(cs_oval), 32'hD);
        chk("dis_sck_oe",  32'(sck_oe),  32'h0);
        chk("dis_dq_oe",   32'(dq_oe),   32'h0);

        // Enable, all lanes driving
        cfg_en = 1'b1; spi_dq_oe = 4'hF; spi_dq_o = 4'hA;
        cfg_ds = 1'b1; spi_sck = 1'b1; spi_cs = 4'hE;
        tick();
        chk("out_dq_oval", 32'(dq_oval), 32'hA);
        chk("out_dq_oe",   32'(dq_oe),   32'hF);
        chk("out_dq_ie",   32'(dq_ie),   32'h0);
        chk("out_sck",     32'({sck_oval, sck_oe}), 32'h3);
        chk("out_dq_ds",   32'(dq_ds),   32'hF);
        chk("out_cs_oval", 32'(cs_oval), 32'h3);
        chk("out_cs_oe",   32'(cs_oe),   32'hF);

        // Turnaround OUT -> TURN -> IN
        spi_dq_oe = 4'h0;
        tick();
        chk("turn_oe",   32'(dq_oe),     32'h0);
        chk("turn_flag", 32'(lane_turn), 32'hF);
        chk("turn_ie",   32'(dq_ie),     32'h0);
        tick();
        chk("in_ie",   32'(dq_ie),     32'hF);
        chk("in_turn", 32'(lane_turn), 32'h0);

        // RX delay 2: latency 2 + 2 + 1 = 5
        cfg_rx_dly = 3'd2;
        dq_ival = 4'h5;
        ticks(4);
        chk("dly2_early", 32'(spi_dq_i), 32'h0);
        tick();
        chk("dly2_data",  32'(spi_dq_i), 32'h5);

        // RX delay 7 saturates to 5: latency 8
        cfg_rx_dly = 3'd7;
        ticks(10);
        chk("sat_steady", 32'(spi_dq_i), 32'h5);
        dq_ival = 4'hA;
        ticks(7);
        chk("sat_early", 32'(spi_dq_i), 32'h5);
        tick();
        chk("sat_data",  32'(spi_dq_i), 32'hA);

        // RX delay 0: latency 3
        cfg_rx_dly = 3'd0;
        ticks(3);
        dq_ival = 4'h3;
        ticks(2);
        chk("dly0_early", 32'(spi_dq_i), 32'hA);
        tick();
        chk("dly0_data",  32'(spi_dq_i), 32'h3);

        // IN -> OUT -> TURN -> OUT (reassert during TURN)
        spi_dq_oe = 4'hF;
        tick();
        chk("in2out_oe", 32'(dq_oe),    32'hF);
        chk("in2out_ie", 32'(dq_ie),    32'h0);
        chk("in2out_rx", 32'(spi_dq_i), 32'h3);
        spi_dq_oe = 4'h0;
        tick();
        chk("turn2_flag", 32'(lane_turn), 32'hF);
        chk("turn2_rx",   32'(spi_dq_i),  32'h0);
        spi_dq_oe = 4'hF;
        tick();
        chk("reout_oe",   32'(dq_oe),     32'hF);
        chk("reout_ie",   32'(dq_ie),     32'h0);
        chk("reout_turn", 32'(lane_turn), 32'h0);

        // Mixed lanes: 0,1 keep driving, 2,3 turn around
        spi_dq_oe = 4'h3; dq_ival = 4'hF;
        tick();
        chk("mix_oe",   32'(dq_oe),     32'h3);
        chk("mix_turn", 32'(lane_turn), 32'hC);
        tick();
        chk("mix_ie",   32'(dq_ie),     32'hC);
        tick();
        chk("mix_rx",   32'(spi_dq_i),  32'hC);

        // Disable from any state -> IDLE
        cfg_en = 1'b0;
        tick();
        chk("idle_oe",      32'(dq_oe),     32'h0);
        chk("idle_ie",      32'(dq_ie),     32'h0);
        chk("idle_turn",    32'(lane_turn), 32'h0);
        chk("idle_cs_oval", 32'(cs_oval),   32'hD);
        chk("idle_cs_oe",   32'(cs_oe),     32'hF);
        chk("idle_sck_oe",  32'(sck_oe),    32'h0);
        tick();
        chk("idle_rx",      32'(spi_dq_i),  32'h0);

        // Reset in the middle of OUT
        cfg_en = 1'b1; spi_dq_oe = 4'hF;
        tick();
        chk("pre_rst_oe", 32'(dq_oe), 32'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_oe",    32'(dq_oe),   32'h0);
        chk("midrst_cs_oe", 32'(cs_oe),   32'h0);
        chk("midrst_cs",    32'(cs_oval), 32'hD);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef N101_SPI_PADPORT_LOOPBACK_EN
        // Loopback: registered spi_dq_o feeds the delay line, pads stay off
        cfg_lpbk = 1'b1; spi_dq_oe = 4'h0; spi_dq_o = 4'h9; cfg_rx_dly = 3'd0;
        ticks(4);
        chk("lpbk_rx", 32'(spi_dq_i), 32'h9);
        chk("lpbk_oe", 32'(dq_oe),    32'h0);
        chk("lpbk_ie", 32'(dq_ie),    32'hF);
        spi_dq_o = 4'h6;
        tick();
        chk("lpbk_early", 32'(spi_dq_i), 32'h9);
        tick();
        chk("lpbk_data",  32'(spi_dq_i), 32'h6);
        spi_dq_oe = 4'hF;
        tick();
        chk("lpbk_force_oe", 32'(dq_oe), 32'h0);
        chk("lpbk_out_ie",   32'(dq_ie), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
